// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
// Gate length is 2^(gate_sel + GATE_EXP_BASE) clk cycles.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meas_state_t;

    localparam int GATE_EXP_BASE = 8;
    localparam int GSEL_W        = 3;
    // Wide enough for the longest gate (2^15) and WARM_CYC up to 255.
    localparam int TMR_W         = 16;

    function automatic logic [TMR_W-1:0] gate_last(input logic [GSEL_W-1:0] sel);
        return (TMR_W'(1) << (32'(sel) + GATE_EXP_BASE)) - TMR_W'(1);
    endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer plus previous-value register; rise pulses one cycle per rising edge.
// Latency: 2-3 clk from the asynchronous edge to rise; no backpressure.
module ro_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator frequency measurement: warm up, count edges over a 2^(gate_sel+8) gate, report.
// Latency: done at T+WARM_CYC+G+1 after start; no backpressure. Define RO_MEAS_CONT_EN for back-to-back runs.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WARM_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GSEL_W-1:0] gate_sel,
    input  logic              ro_in,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [TMR_W-1:0] WARM_LAST = TMR_W'(WARM_CYC - 1);

    meas_state_t       state_q, state_d;
    logic [TMR_W-1:0]  tmr_q;
    logic [GSEL_W-1:0] gsel_q;
    logic [CNT_W-1:0]  edge_cnt, cnt_nxt;
    logic              edge_ovf, ovf_nxt;
    logic              rise;
    logic              accept_start, restart, load, gate_close, tmr_zero;

    ro_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (ro_in),
        .rise    (rise)
    );

    assign tmr_zero     = (tmr_q == '0);
    assign accept_start = (state_q == ST_IDLE) && start && !abort;
`ifdef RO_MEAS_CONT_EN
    assign restart      = (state_q == ST_DONE) && start;
`else
    assign restart      = 1'b0;
`endif
    assign load         = accept_start || restart;
    assign gate_close   = (state_q == ST_MEASURE) && tmr_zero && !abort;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept_start) state_d = ST_WARMUP;
            ST_WARMUP:  if (abort) state_d = ST_IDLE;
                        else if (tmr_zero) state_d = ST_MEASURE;
            ST_MEASURE: if (abort) state_d = ST_IDLE;
                        else if (tmr_zero) state_d = ST_DONE;
            ST_DONE:    state_d = restart ? ST_WARMUP : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_WARMUP) || (state_q == ST_MEASURE);
        done  = (state_q == ST_DONE);
        // Keeping the oscillator enabled through a restarting DONE avoids a needless re-settle glitch.
        ro_en = busy || restart;
    end

    // Saturating edge counter next value; includes the edge seen in the gate's last cycle.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = edge_ovf;
        if ((state_q == ST_MEASURE) && rise) begin
            if (edge_cnt == '1) ovf_nxt = 1'b1;
            else                cnt_nxt = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q    <= '0;
            gsel_q   <= '0;
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                gsel_q   <= gate_sel;
                edge_cnt <= '0;
                edge_ovf <= 1'b0;
                tmr_q    <= WARM_LAST;
            end else if (state_q == ST_WARMUP) begin
                tmr_q <= tmr_zero ? gate_last(gsel_q) : tmr_q - TMR_W'(1);
            end else if (state_q == ST_MEASURE) begin
                tmr_q    <= tmr_q - TMR_W'(1);
                edge_cnt <= cnt_nxt;
                edge_ovf <= ovf_nxt;
            end
            // Published result changes only at a completed gate; abort leaves the old one.
            if (gate_close) begin
                count    <= cnt_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: latency, edge count, saturation, abort, reset and start-ignore cases.
// Two instances: 16-bit counter (period-8 ro_in) and 8-bit counter (period-4 ro_in) for saturation.
module tb_ro_meas_ctrl;

    localparam int WARM = 16;
    localparam int LAT0 = WARM + 256 + 1;   // gate_sel=0
    localparam int LAT2 = WARM + 1024 + 1;  // gate_sel=2

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [2:0]  gate_sel = 3'd0;
    logic        ro_in = 1'b0;
    logic        ro_en, busy, done, overflow;
    logic [15:0] count;

    logic        start8 = 1'b0, abort8 = 1'b0;
    logic [2:0]  gate_sel8 = 3'd2;
    logic        ro_in4 = 1'b0;
    logic        ro_en8, busy8, done8, overflow8;
    logic [7:0]  count8;

    logic [2:0]  ro_div = 3'd0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Synthetic oscillators: period 8 and period 4 clk, changing away from the sampling edge.
    always @(negedge clk) begin
        ro_div = ro_div + 3'd1;
        ro_in  = ro_div[2];
        ro_in4 = ro_div[1];
    end

    ro_meas_ctrl #(.CNT_W(16), .WARM_CYC(WARM)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_sel(gate_sel),
        .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .done(done),
        .count(count), .overflow(overflow)
    );

    ro_meas_ctrl #(.CNT_W(8), .WARM_CYC(WARM)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .gate_sel(gate_sel8),
        .ro_in(ro_in4), .ro_en(ro_en8), .busy(busy8), .done(done8),
        .count(count8), .overflow(overflow8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; on return we are in cycle T+1.
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count cycles until done (bounded); returns T+k index of the done cycle.
    task automatic wait_done(input int limit, output int k);
        k = limit + 1;
        for (int i = 2; i <= limit; i++) begin
            tick();
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    int k;
    int ndone;
    bit en_drop;

    initial begin
        // Reset, with start high to confirm reset precedence
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ro_en", ro_en, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Basic measurement: 256-cycle gate, period-8 input -> 32 edges
        gate_sel = 3'd0;
        kick();
        chk("warm_busy", busy, 1);
        chk("warm_ro_en", ro_en, 1);
        gate_sel = 3'd5;  // must not affect the latched gate
        wait_done(LAT0 + 20, k);
        chk("lat_basic", k, LAT0);
        chk("done_busy", busy, 0);
        chk("done_ro_en", ro_en, 0);
        chk("cnt_basic", count, 32);
        chk("ovf_basic", overflow, 0);
        tick();
        chk("done_pulse1", done, 0);
        chk("count_hold", count, 32);

        // Start pulses during WARMUP and MEASURE are ignored
        gate_sel = 3'd0;
        kick();
        ndone = 0;
        for (int i = 2; i < LAT0; i++) begin
            start = (i == 5 || i == 100);
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        chk("ign_early_done", ndone, 0);
        tick();
        chk("ign_done_at", done, 1);
        chk("ign_cnt", count, 32);
        tick();
        chk("ign_no_restart", busy, 0);

        // Abort 100 cycles into MEASURE
        kick();
        repeat (WARM + 100) tick();
        chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ro_en", ro_en, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", count, 32);
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("abort_quiet", ndone, 0);

        // Abort in IDLE, and start+abort together in IDLE, do nothing
        abort = 1'b1;
        tick();
        chk("idle_abort", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", busy, 0);
        chk("start_abort_cnt", count, 32);

        // Reset mid-MEASURE, then a normal run
        kick();
        repeat (WARM + 50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_ro_en", ro_en, 0);
        chk("mrst_cnt", count, 0);
        tick();
        chk("mrst_idle", busy, 0);
        kick();
        wait_done(LAT0 + 20, k);
        chk("mrst_lat", k, LAT0);
        chk("mrst_meas", count, 32);

        // Saturation on the 8-bit instance: 1024-cycle gate, period-4 input -> 256 edges
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        k = LAT2 + 21;
        for (int i = 2; i <= LAT2 + 20; i++) begin
            tick();
            if (done8) begin
                k = i;
                break;
            end
        end
        chk("sat_lat", k, LAT2);
        chk("sat_cnt", count8, 255);
        chk("sat_ovf", overflow8, 1);
        tick();
        chk("sat_ovf_hold", overflow8, 1);

        // Start while in DONE
        kick();
        wait_done(LAT0 + 20, k);
        chk("cont_first", k, LAT0);
        start = 1'b1;
        #1;
`ifdef RO_MEAS_CONT_EN
        chk("cont_ro_en_done", ro_en, 1);
        en_drop = 1'b0;
        for (int p = 0; p < 2; p++) begin
            k = LAT0 + 20;
            for (int i = 1; i <= LAT0 + 20; i++) begin
                tick();
                if (!ro_en) en_drop = 1'b1;
                if (done) begin
                    k = i;
                    break;
                end
            end
            chk("cont_period", k, LAT0);
            chk("cont_cnt", count, 32);
        end
        chk("cont_ro_en_held", en_drop, 0);
        start = 1'b0;
        tick();
        chk("cont_stop", busy, 0);
`else
        chk("done_start_ro_en", ro_en, 0);
        tick();
        start = 1'b0;
        chk("done_start_ign", busy, 0);
        tick();
        chk("done_start_idle", busy, 0);
        en_drop = ro_en;
        chk("done_start_en", en_drop, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
